// File: rtl/camera_capture_stream.sv
// Parallel camera byte-stream capture: VSYNC/HREF/D to 16-bit pixel words with addresses and frame markers.
// Optional build macro CAM_CAPTURE_STATS_EN adds frame_count and last_line_len outputs.
module camera_capture_stream #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DEC_LOG2 = 0
) (
  input  logic                         PCLK,
  input  logic                         RESET,
  input  logic                         capture_en,
  input  logic                         mode_rgb,
  input  logic                         VSYNC,
  input  logic                         HREF,
  input  logic [7:0]                   D,
`ifdef CAM_CAPTURE_STATS_EN
  output logic [15:0]                  frame_count,
  output logic [11:0]                  last_line_len,
`endif
  output logic                         pix_valid,
  output logic [15:0]                  pix_data,
  output logic [7:0]                   pix_luma,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [$clog2(H_ACTIVE)-1:0]  col,
  output logic [$clog2(V_ACTIVE)-1:0]  row,
  output logic                         frame_start,
  output logic                         frame_done,
  output logic                         line_err,
  output logic                         frame_err
);

  // state   | meaning
  // WAIT_VS | idle after reset or a disabled frame; waiting for a clean frame boundary
  // ARMED   | VSYNC high; latching capture_en/mode_rgb for the next frame
  // ACTIVE  | capturing lines of an enabled frame
  localparam logic [1:0] WAIT_VS = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;

  localparam int COL_W = $clog2(H_ACTIVE);
  localparam int ROW_W = $clog2(V_ACTIVE);
  // Raw counters are wider than needed and saturate so over-long lines/frames never alias to legal ones.
  localparam int RC_W  = ($clog2(H_ACTIVE + 1) + 1 > 12) ? $clog2(H_ACTIVE + 1) + 1 : 12;
  localparam int RR_W  = $clog2(V_ACTIVE + 1) + 1;

  localparam logic [RC_W-1:0] H_RC  = RC_W'(H_ACTIVE);
  localparam logic [RR_W-1:0] V_RR  = RR_W'(V_ACTIVE);
  localparam logic [RC_W-1:0] CMASK = RC_W'((1 << DEC_LOG2) - 1);
  localparam logic [RR_W-1:0] RMASK = RR_W'((1 << DEC_LOG2) - 1);

  logic [1:0]        state;
  logic              en_lat;
  logic              rgb_lat;
  logic [1:0]        phase;
  logic [7:0]        byte0;
  logic              href_q;
  logic [RC_W-1:0]   raw_col;
  logic [RR_W-1:0]   raw_row;
  logic [ADDR_W-1:0] addr_cnt;
  logic              first_pix;

  logic capturing;
  logic line_kept;
  logic keep_pix;

  always_comb begin
    capturing = (state == ACTIVE) && !VSYNC;
    line_kept = (raw_row < V_RR) && ((raw_row & RMASK) == '0);
    keep_pix  = capturing && HREF && phase[0] && line_kept &&
                (raw_col < H_RC) && ((raw_col & CMASK) == '0);
  end

  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      state       <= WAIT_VS;
      en_lat      <= 1'b0;
      rgb_lat     <= 1'b0;
      phase       <= 2'd0;
      byte0       <= 8'd0;
      href_q      <= 1'b0;
      raw_col     <= '0;
      raw_row     <= '0;
      addr_cnt    <= '0;
      first_pix   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'd0;
      pix_luma    <= 8'd0;
      wr_addr     <= '0;
      col         <= '0;
      row         <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      href_q      <= capturing && HREF;
      if (VSYNC) begin
        en_lat  <= capture_en;
        rgb_lat <= mode_rgb;
      end
      case (state)
        WAIT_VS: begin
          if (VSYNC) state <= ARMED;
        end
        ARMED: begin
          phase     <= 2'd0;
          raw_col   <= '0;
          raw_row   <= '0;
          addr_cnt  <= '0;
          first_pix <= 1'b1;
          if (!VSYNC) state <= en_lat ? ACTIVE : WAIT_VS;
        end
        ACTIVE: begin
          if (VSYNC) begin
            frame_done <= 1'b1;
            if (raw_row != V_RR) frame_err <= 1'b1;
            phase   <= 2'd0;
            raw_col <= '0;
            raw_row <= '0;
            state   <= ARMED;
          end else if (HREF) begin
            phase <= phase + 2'd1;
            if (!phase[0]) byte0 <= D;
            if (phase[0] && raw_col != '1) raw_col <= raw_col + 1'b1;
            if (keep_pix) begin
              pix_valid   <= 1'b1;
              pix_data    <= rgb_lat ? {byte0, D} : {D, byte0};
              pix_luma    <= rgb_lat ? byte0 : D;
              wr_addr     <= addr_cnt;
              col         <= COL_W'(raw_col >> DEC_LOG2);
              row         <= ROW_W'(raw_row >> DEC_LOG2);
              frame_start <= first_pix;
              first_pix   <= 1'b0;
              addr_cnt    <= addr_cnt + 1'b1;
            end
          end else begin
            phase <= 2'd0;
            if (href_q) begin
              // A dangling odd byte is simply dropped with the phase clear.
              if (raw_col != H_RC || phase[0]) line_err <= 1'b1;
              if (raw_row != '1) raw_row <= raw_row + 1'b1;
              raw_col <= '0;
            end
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

`ifdef CAM_CAPTURE_STATS_EN
  always_ff @(posedge PCLK or negedge RESET) begin
    if (!RESET) begin
      frame_count   <= 16'd0;
      last_line_len <= 12'd0;
    end else begin
      if (state == ACTIVE && VSYNC) frame_count <= frame_count + 16'd1;
      if (capturing && !HREF && href_q) last_line_len <= raw_col[11:0];
    end
  end
`endif

endmodule

// File: tb/tb_camera_capture_stream.sv
// Bench for camera_capture_stream: two instances (full-rate H4xV2, decimated H4xV4) driven by directed frames.
// Expected pixels are pushed to per-instance queues as bytes are driven and popped when pix_valid appears.
module tb_camera_capture_stream;

  logic       PCLK = 1'b0;
  logic       RESET = 1'b0;
  logic       capture_en = 1'b0;
  logic       mode_rgb = 1'b0;
  logic       vs = 1'b1;
  logic       href = 1'b0;
  logic [7:0] d = 8'd0;
  int         tgt = 0;

  logic vs0, hr0, vs1, hr1;
  assign vs0 = (tgt == 0) ? vs : 1'b1;
  assign hr0 = (tgt == 0) ? href : 1'b0;
  assign vs1 = (tgt == 1) ? vs : 1'b1;
  assign hr1 = (tgt == 1) ? href : 1'b0;

  always #5 PCLK = ~PCLK;

  logic        pv0, fs0, fd0, le0, fe0;
  logic [15:0] pd0;
  logic [7:0]  pl0;
  logic [2:0]  wa0;
  logic [1:0]  c0;
  logic [0:0]  r0;
  logic        pv1, fs1, fd1, le1, fe1;
  logic [15:0] pd1;
  logic [7:0]  pl1;
  logic [1:0]  wa1;
  logic [1:0]  c1;
  logic [1:0]  r1;
`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] fc0, fc1;
  logic [11:0] ll0, ll1;
`endif

  camera_capture_stream #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3), .DEC_LOG2(0)) dut (
`ifdef CAM_CAPTURE_STATS_EN
    .frame_count(fc0), .last_line_len(ll0),
`endif
    .PCLK(PCLK), .RESET(RESET), .capture_en(capture_en), .mode_rgb(mode_rgb),
    .VSYNC(vs0), .HREF(hr0), .D(d),
    .pix_valid(pv0), .pix_data(pd0), .pix_luma(pl0), .wr_addr(wa0), .col(c0), .row(r0),
    .frame_start(fs0), .frame_done(fd0), .line_err(le0), .frame_err(fe0)
  );

  camera_capture_stream #(.H_ACTIVE(4), .V_ACTIVE(4), .ADDR_W(2), .DEC_LOG2(1)) dut_dec (
`ifdef CAM_CAPTURE_STATS_EN
    .frame_count(fc1), .last_line_len(ll1),
`endif
    .PCLK(PCLK), .RESET(RESET), .capture_en(capture_en), .mode_rgb(mode_rgb),
    .VSYNC(vs1), .HREF(hr1), .D(d),
    .pix_valid(pv1), .pix_data(pd1), .pix_luma(pl1), .wr_addr(wa1), .col(c1), .row(r1),
    .frame_start(fs1), .frame_done(fd1), .line_err(le1), .frame_err(fe1)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  luma;
    logic [7:0]  addr;
    logic [7:0]  col;
    logic [7:0]  row;
    logic        fs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int passed = 0;
  int failed = 0;

  int exp_addr[2];
  int rr[2];
  bit first[2];
  bit cap_now[2];
  bit rgb_now[2];
  bit exp_le[2];
  bit exp_fe[2];
  int exp_fd[2];
  int fdc[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int t, input logic pv, input logic [15:0] pd, input logic [7:0] pl,
                     input logic [7:0] wa, input logic [7:0] c, input logic [7:0] r, input logic fs);
    exp_t e;
    if ((t == 0 && q0.size() == 0) || (t == 1 && q1.size() == 0)) begin
      check($sformatf("pix_unexpected%0d", t), {31'd0, pv}, 32'd0);
    end else begin
      e = (t == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("pix_data%0d", t), {16'd0, pd}, {16'd0, e.data});
      check($sformatf("pix_luma%0d", t), {24'd0, pl}, {24'd0, e.luma});
      check($sformatf("wr_addr%0d", t), {24'd0, wa}, {24'd0, e.addr});
      check($sformatf("col%0d", t), {24'd0, c}, {24'd0, e.col});
      check($sformatf("row%0d", t), {24'd0, r}, {24'd0, e.row});
      check($sformatf("frame_start%0d", t), {31'd0, fs}, {31'd0, e.fs});
    end
  endtask

  always @(negedge PCLK) begin
    if (pv0) mon(0, pv0, pd0, pl0, 8'(wa0), 8'(c0), 8'(r0), fs0);
    else if (fs0) check("fs_without_pv0", {31'd0, fs0}, 32'd0);
    if (pv1) mon(1, pv1, pd1, pl1, 8'(wa1), 8'(c1), 8'(r1), fs1);
    else if (fs1) check("fs_without_pv1", {31'd0, fs1}, 32'd0);
    if (fd0) fdc[0]++;
    if (fd1) fdc[1]++;
  end

  function automatic int dec_of(input int t);
    return (t == 0) ? 1 : 2;
  endfunction

  function automatic int v_of(input int t);
    return (t == 0) ? 2 : 4;
  endfunction

  // One HREF line of nbytes: even bytes se+k, odd bytes so+k for pixel k.
  task automatic line(input int t, input int nbytes, input logic [7:0] se, input logic [7:0] so);
    exp_t e;
    int p;
    int dc;
    logic [7:0] b;
    logic [7:0] prev;
    dc = dec_of(t);
    for (int i = 0; i < nbytes; i++) begin
      p = i / 2;
      b = (i % 2 == 0) ? se + 8'(p) : so + 8'(p);
      href = 1'b1;
      d = b;
      if (i % 2 == 1) begin
        prev = se + 8'(p);
        if (cap_now[t] && rr[t] < v_of(t) && rr[t] % dc == 0 && p < 4 && p % dc == 0) begin
          e.data = rgb_now[t] ? {prev, b} : {b, prev};
          e.luma = rgb_now[t] ? prev : b;
          e.addr = 8'(exp_addr[t]);
          e.col  = 8'(p / dc);
          e.row  = 8'(rr[t] / dc);
          e.fs   = first[t];
          first[t] = 1'b0;
          exp_addr[t]++;
          if (t == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
      @(negedge PCLK);
    end
    href = 1'b0;
    d = 8'd0;
    if (cap_now[t] && nbytes != 8) exp_le[t] = 1'b1;
    rr[t]++;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic frame_begin(input int t, input bit cap, input bit rgb);
    tgt = t;
    capture_en = cap;
    mode_rgb = rgb;
    vs = 1'b1;
    repeat (3) @(negedge PCLK);
    vs = 1'b0;
    cap_now[t] = cap;
    rgb_now[t] = rgb;
    first[t] = 1'b1;
    exp_addr[t] = 0;
    rr[t] = 0;
    repeat (2) @(negedge PCLK);
  endtask

  task automatic frame_end(input int t, input string tag);
    vs = 1'b1;
    if (cap_now[t]) begin
      exp_fd[t]++;
      if (rr[t] != v_of(t)) exp_fe[t] = 1'b1;
    end
    repeat (3) @(negedge PCLK);
    check({tag, "_frame_done"}, 32'(fdc[t]), 32'(exp_fd[t]));
    check({tag, "_line_err"}, {31'd0, (t == 0) ? le0 : le1}, {31'd0, exp_le[t]});
    check({tag, "_frame_err"}, {31'd0, (t == 0) ? fe0 : fe1}, {31'd0, exp_fe[t]});
    check({tag, "_pending"}, 32'((t == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int t = 0; t < 2; t++) begin
      exp_addr[t] = 0; rr[t] = 0; first[t] = 0; cap_now[t] = 0; rgb_now[t] = 0;
      exp_le[t] = 0; exp_fe[t] = 0; exp_fd[t] = 0; fdc[t] = 0;
    end
    // Reset held with a frame already running on instance 0.
    tgt = 0;
    vs = 1'b0;
    capture_en = 1'b1;
    repeat (3) @(negedge PCLK);
    check("rst_pix_valid", {31'd0, pv0}, 32'd0);
    check("rst_pix_data", {16'd0, pd0}, 32'd0);
    check("rst_wr_addr", {29'd0, wa0}, 32'd0);
    check("rst_frame_done", {31'd0, fd0}, 32'd0);
    check("rst_errs", {30'd0, le0, fe0}, 32'd0);
    check("rst_dec_pix_data", {16'd0, pd1}, 32'd0);
    href = 1'b1;
    d = 8'h33;
    repeat (3) @(negedge PCLK);
    RESET = 1'b1;
    repeat (5) @(negedge PCLK);
    href = 1'b0;
    repeat (2) @(negedge PCLK);
    cap_now[0] = 1'b0;
    line(0, 8, 8'h40, 8'h50);
    frame_end(0, "midreset");

    frame_begin(0, 1'b1, 1'b0);
    line(0, 8, 8'h10, 8'h14);
    line(0, 8, 8'h20, 8'h24);
    frame_end(0, "ycbcr");

    frame_begin(0, 1'b1, 1'b1);
    line(0, 8, 8'hF8, 8'h00);
    line(0, 8, 8'h07, 8'hE0);
    frame_end(0, "rgb");

    frame_begin(0, 1'b0, 1'b0);
    line(0, 8, 8'h60, 8'h70);
    capture_en = 1'b1;
    line(0, 8, 8'h61, 8'h71);
    frame_end(0, "disabled");

    frame_begin(0, 1'b1, 1'b0);
    line(0, 8, 8'h80, 8'h90);
    capture_en = 1'b0;
    mode_rgb = 1'b1;
    line(0, 8, 8'h81, 8'h91);
    frame_end(0, "toggle_mid");

    frame_begin(0, 1'b1, 1'b0);
    line(0, 10, 8'hA0, 8'hB0);
    line(0, 9, 8'hA8, 8'hB8);
    frame_end(0, "badlines");

    frame_begin(0, 1'b1, 1'b0);
    line(0, 8, 8'hC0, 8'hD0);
    line(0, 8, 8'hC4, 8'hD4);
    frame_end(0, "sticky");

    frame_begin(1, 1'b1, 1'b0);
    for (int l = 0; l < 4; l++) line(1, 8, 8'h10 + 8'(l), 8'h40 + 8'(l));
    frame_end(1, "dec_clean");

    frame_begin(1, 1'b1, 1'b0);
    for (int l = 0; l < 3; l++) line(1, 8, 8'h20 + 8'(l), 8'h50 + 8'(l));
    frame_end(1, "dec_short");

    tgt = 0;
    repeat (3) @(negedge PCLK);
    check("final_frame_err0", {31'd0, fe0}, 32'd0);
    check("final_line_err1", {31'd0, le1}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
